mii_mac_tx: RTL and testbench

Transmit-side MII MAC. Accepts a frame as a byte stream with a valid/ready/last handshake: destination MAC, source MAC, ethertype and payload, already assembled upstream. It emits nibbles on MII with preamble and SFD prepended, optional zero padding, and a 32-bit FCS appended. It then enforces the inter-frame gap. It pairs with the receive MAC and is its loopback partner in system benches.

---
 rtl/mii_mac_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_mii_mac_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_mac_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mii_mac_tx : MII transmit MAC - preamble/SFD, CRC-32 FCS, IFG.      |
// | Optional pad-to-minimum enabled by defining MII_MAC_TX_PAD_EN.      |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module mii_mac_tx #(
   parameter int PREAMBLE_LEN  = 7,
   parameter int MIN_FRAME_LEN = 60,
   parameter int IFG_CYCLES    = 24
) (
   input  logic       tx_clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       data_last,
   output logic       data_ready,
   output logic [3:0] tx_data,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy,
   output logic       underrun
);

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_PREAMBLE = 4'd1,
      ST_SFD      = 4'd2,
      ST_DATA     = 4'd3,
      ST_FCS      = 4'd4,
      ST_ABORT    = 4'd5,
      ST_IFG      = 4'd6
`ifdef MII_MAC_TX_PAD_EN
      , ST_PAD    = 4'd7
`endif
   } state_t;

   localparam logic [7:0] c_PRE_LAST = 8'(2 * PREAMBLE_LEN - 1);
   // The IDLE cycle that precedes the next preamble completes the gap.
   localparam logic [7:0] c_IFG_LAST = 8'(IFG_CYCLES - 2);
`ifdef MII_MAC_TX_PAD_EN
   localparam logic [15:0] c_MIN_LEN = 16'(MIN_FRAME_LEN);
`endif

   // The byte counter is 16 bits wide, so a larger minimum could never be met.
   if (MIN_FRAME_LEN > 65535) begin : g_min_len_unreachable
   end

   state_t      r_state;
   logic [31:0] r_crc;
   logic [27:0] r_fcs_sh;
   logic [7:0]  r_cnt;
   logic [15:0] r_byte_cnt;
   byte_t       r_byte;
   logic        r_last;
   logic        r_phase;
   logic [31:0] w_fcs;

   assign w_fcs = ~r_crc;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input byte_t b);
      logic [31:0] x;
      x = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      end
      return x;
   endfunction

   always_ff @(posedge tx_clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         tx_data    <= 4'h0;
         tx_en      <= 1'b0;
         tx_er      <= 1'b0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         underrun   <= 1'b0;
         r_crc      <= 32'hFFFFFFFF;
         r_fcs_sh   <= 28'h0;
         r_cnt      <= 8'd0;
         r_byte_cnt <= 16'd0;
         r_byte     <= 8'h00;
         r_last     <= 1'b0;
         r_phase    <= 1'b0;
      end else begin
         underrun <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (data_valid) begin
                  r_state    <= ST_PREAMBLE;
                  tx_en      <= 1'b1;
                  tx_data    <= 4'h5;
                  busy       <= 1'b1;
                  r_phase    <= 1'b0;
                  r_cnt      <= 8'd0;
                  r_byte_cnt <= 16'd0;
               end
            end
            ST_PREAMBLE: begin
               r_phase <= ~r_phase;
               if (r_cnt == c_PRE_LAST) begin
                  r_state <= ST_SFD;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_SFD: begin
               if (!r_phase) begin
                  tx_data    <= 4'hD;
                  data_ready <= 1'b1;
                  r_crc      <= 32'hFFFFFFFF;
                  r_phase    <= 1'b1;
               end else if (data_valid) begin
                  r_state    <= ST_DATA;
                  r_byte     <= data_in;
                  r_last     <= data_last;
                  tx_data    <= data_in[3:0];
                  data_ready <= 1'b0;
                  r_phase    <= 1'b0;
               end else begin
                  r_state    <= ST_ABORT;
                  tx_er      <= 1'b1;
                  tx_data    <= 4'h0;
                  data_ready <= 1'b0;
                  underrun   <= 1'b1;
                  r_cnt      <= 8'd0;
               end
            end
            ST_DATA: begin
               if (!r_phase) begin
                  tx_data    <= r_byte[7:4];
                  r_crc      <= crc_byte(r_crc, r_byte);
                  r_byte_cnt <= (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
                  data_ready <= ~r_last;
                  r_phase    <= 1'b1;
               end else if (r_last) begin
                  r_phase <= 1'b0;
`ifdef MII_MAC_TX_PAD_EN
                  if (r_byte_cnt < c_MIN_LEN) begin
                     r_state <= ST_PAD;
                     tx_data <= 4'h0;
                  end else
`endif
                  begin
                     r_state  <= ST_FCS;
                     tx_data  <= w_fcs[3:0];
                     r_fcs_sh <= w_fcs[31:4];
                     r_cnt    <= 8'd0;
                  end
               end else if (data_valid) begin
                  r_byte     <= data_in;
                  r_last     <= data_last;
                  tx_data    <= data_in[3:0];
                  data_ready <= 1'b0;
                  r_phase    <= 1'b0;
               end else begin
                  r_state    <= ST_ABORT;
                  tx_er      <= 1'b1;
                  tx_data    <= 4'h0;
                  data_ready <= 1'b0;
                  underrun   <= 1'b1;
                  r_cnt      <= 8'd0;
               end
            end
`ifdef MII_MAC_TX_PAD_EN
            ST_PAD: begin
               if (!r_phase) begin
                  tx_data    <= 4'h0;
                  r_crc      <= crc_byte(r_crc, 8'h00);
                  r_byte_cnt <= r_byte_cnt + 16'd1;
                  r_phase    <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  if (r_byte_cnt >= c_MIN_LEN) begin
                     r_state  <= ST_FCS;
                     tx_data  <= w_fcs[3:0];
                     r_fcs_sh <= w_fcs[31:4];
                     r_cnt    <= 8'd0;
                  end else begin
                     tx_data <= 4'h0;
                  end
               end
            end
`endif
            ST_FCS: begin
               r_phase <= ~r_phase;
               if (r_cnt == 8'd7) begin
                  r_state <= ST_IFG;
                  tx_en   <= 1'b0;
                  tx_data <= 4'h0;
                  r_cnt   <= 8'd0;
               end else begin
                  tx_data  <= r_fcs_sh[3:0];
                  r_fcs_sh <= {4'h0, r_fcs_sh[27:4]};
                  r_cnt    <= r_cnt + 8'd1;
               end
            end
            ST_ABORT: begin
               if (r_cnt == 8'd0) begin
                  r_cnt <= 8'd1;
               end else begin
                  r_state <= ST_IFG;
                  tx_en   <= 1'b0;
                  tx_er   <= 1'b0;
                  tx_data <= 4'h0;
                  r_cnt   <= 8'd0;
               end
            end
            ST_IFG: begin
               if (r_cnt == c_IFG_LAST) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               tx_en      <= 1'b0;
               tx_er      <= 1'b0;
               data_ready <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mii_mac_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mii_mac_tx : directed self-checking bench for mii_mac_tx.        |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_mii_mac_tx;

   localparam int MIN_LEN = 60;

   logic       tx_clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_last;
   logic       data_ready;
   logic [3:0] tx_data;
   logic       tx_en;
   logic       tx_er;
   logic       busy;
   logic       underrun;

   mii_mac_tx dut (
      .tx_clk     (tx_clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .data_ready (data_ready),
      .tx_data    (tx_data),
      .tx_en      (tx_en),
      .tx_er      (tx_er),
      .busy       (busy),
      .underrun   (underrun)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] fb [0:127];

   // Line monitor: monotonic totals only, sampled on the falling edge.
   logic [3:0] nib [0:8191];
   int nib_n = 0, burst_start = 0, burst_len = 0, low_run = 0, last_gap = 0;
   int ready_pulses = 0, ready_even = 0, ready_low = 0, er_cycles = 0;
   int under_pulses = 0, idle_cycles = 0;
   logic prev_en = 1'b0;

   always @(negedge tx_clk) begin
      if (tx_en) begin
         if (!prev_en) begin
            burst_start = nib_n;
            last_gap    = low_run;
            burst_len   = 0;
         end
         if (nib_n < 8192) begin
            nib[nib_n] = tx_data;
            nib_n++;
         end
         burst_len++;
         if (data_ready) begin
            ready_pulses++;
            if (((nib_n - 1 - burst_start) % 2) == 0) ready_even++;
         end
         if (tx_er) er_cycles++;
         low_run = 0;
      end else begin
         low_run++;
         if (data_ready) ready_low++;
      end
      if (underrun) under_pulses++;
      if (!busy) idle_cycles++;
      prev_en = tx_en;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_model(input int len, input int plen);
      logic [31:0] c;
      logic [7:0]  b;
      logic        fbit;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < plen; i++) begin
         b = (i < len) ? fb[i] : 8'h00;
         for (int k = 0; k < 8; k++) begin
            fbit = c[0] ^ b[k];
            c = c >> 1;
            if (fbit) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   task automatic send_frame(input int len, input int drop_at, input int rst_at);
      int idx, pulses, guard;
      idx = 0; pulses = 0; guard = 0;
      data_in = fb[0]; data_last = (len == 1); data_valid = 1'b1;
      while (idx < len && guard < 4000) begin
         @(negedge tx_clk); #1;
         guard++;
         if (data_ready) begin
            pulses++;
            if (pulses == drop_at) begin
               data_valid = 1'b0; data_last = 1'b0;
               return;
            end
            if (pulses == rst_at) begin
               rst_n = 1'b0; data_valid = 1'b0; data_last = 1'b0;
               @(posedge tx_clk); #1;
               check("rst_mid_tx_en", tx_en, 0);
               check("rst_mid_tx_er", tx_er, 0);
               check("rst_mid_busy", busy, 0);
               check("rst_mid_ready", data_ready, 0);
               rst_n = 1'b1;
               return;
            end
            @(posedge tx_clk); #1;
            idx++;
            if (idx < len) begin
               data_in = fb[idx]; data_last = (idx == len - 1);
            end else begin
               data_valid = 1'b0; data_last = 1'b0;
            end
         end
      end
      check("send_done", idx, len);
   endtask

   task automatic wait_en_fall();
      int g = 0;
      while (tx_en && g < 2000) begin
         @(negedge tx_clk); #1;
         g++;
      end
      check("en_fall_timeout", tx_en, 0);
   endtask

   task automatic wait_busy_low();
      int g = 0;
      while (busy && g < 2000) begin
         @(negedge tx_clk); #1;
         g++;
      end
      check("busy_low_timeout", busy, 0);
   endtask

   task automatic check_frame(input string tag, input int len);
      int plen, base, bad;
      logic [31:0] fcs_obs;
      logic [7:0]  b;
      plen = len;
`ifdef MII_MAC_TX_PAD_EN
      if (plen < MIN_LEN) plen = MIN_LEN;
`endif
      base = burst_start;
      check({tag, "_en_len"}, burst_len, 16 + 2 * plen + 8);
      bad = 0;
      for (int i = 0; i < 15; i++) if (nib[base + i] !== 4'h5) bad++;
      if (nib[base + 15] !== 4'hD) bad++;
      check({tag, "_preamble_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < plen; i++) begin
         b = (i < len) ? fb[i] : 8'h00;
         if (nib[base + 16 + 2 * i] !== b[3:0] || nib[base + 17 + 2 * i] !== b[7:4]) bad++;
      end
      check({tag, "_data_bad"}, bad, 0);
      fcs_obs = 32'h0;
      for (int k = 0; k < 8; k++) fcs_obs[4 * k +: 4] = nib[base + 16 + 2 * plen + k];
      check({tag, "_fcs"}, fcs_obs, crc_model(len, plen));
   endtask

   initial begin
      int rp0, re0, rl0, er0, up0, id0;
      logic [31:0] fcs_obs;

      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rp0, re0, rl0, er0, up0, id0;
      rst_n = 1'b0; data_in = 8'h00; data_valid = 1'b0; data_last = 1'b0;
      repeat (3) @(posedge tx_clk);
      #1;
      check("reset_tx_en", tx_en, 0);
      check("reset_tx_er", tx_er, 0);
      check("reset_tx_data", tx_data, 0);
      check("reset_ready", data_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_underrun", underrun, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge tx_clk);
      #1;
      check("idle_busy", busy, 0);

      // 1-byte frame
      fb[0] = 8'hAB;
      rp0 = ready_pulses;
      send_frame(1, 0, 0);
      wait_en_fall();
      check_frame("one_byte", 1);
      check("one_byte_ready_pulses", ready_pulses - rp0, 1);
      wait_busy_low();

      // "123456789"
      for (int i = 0; i < 9; i++) fb[i] = 8'(8'h31 + i);
      rp0 = ready_pulses;
      send_frame(9, 0, 0);
      wait_en_fall();
      check_frame("ascii9", 9);
      check("ascii9_ready_pulses", ready_pulses - rp0, 9);
`ifndef MII_MAC_TX_PAD_EN
      begin
         logic [31:0] f;
         f = 32'h0;
         for (int k = 0; k < 8; k++) f[4 * k +: 4] = nib[burst_start + 34 + k];
         check("ascii9_fcs_const", f, 32'hCBF43926);
         check("ascii9_en_42", burst_len, 42);
      end
`endif
      wait_busy_low();

      // 64-byte frame, then a second frame held valid through the IFG
      for (int i = 0; i < 64; i++) fb[i] = 8'(i * 37 + 5);
      rp0 = ready_pulses; re0 = ready_even;
      send_frame(64, 0, 0);
      wait_en_fall();
      check_frame("f64", 64);
      check("f64_ready_pulses", ready_pulses - rp0, 64);
      check("f64_ready_even_phase", ready_even - re0, 0);
      rl0 = ready_low; id0 = idle_cycles;
      for (int i = 0; i < 20; i++) fb[i] = 8'(8'hC0 ^ i);
      send_frame(20, 0, 0);
      check("b2b_gap", last_gap, 24);
      check("b2b_ready_in_gap", ready_low - rl0, 0);
      check("b2b_idle_cycles", idle_cycles - id0, 1);
      wait_en_fall();
      check_frame("b2b_f20", 20);
      wait_busy_low();

      // Underrun at the 10th fetch
      for (int i = 0; i < 40; i++) fb[i] = 8'(i + 8'h60);
      er0 = er_cycles; up0 = under_pulses;
      send_frame(40, 10, 0);
      wait_en_fall();
      check("under_en_len", burst_len, 36);
      check("under_er_cycles", er_cycles - er0, 2);
      check("under_pulses", under_pulses - up0, 1);
      check("under_last_nib_er_zero", nib[burst_start + 35], 0);

      // Next frame held through the post-abort gap, reset mid-payload
      id0 = idle_cycles;
      for (int i = 0; i < 12; i++) fb[i] = 8'(i * 3 + 8'h90);
      send_frame(12, 0, 6);
      check("under_gap", last_gap, 24);
      check("under_idle_cycles", idle_cycles - id0, 1);
      repeat (5) @(negedge tx_clk);
      #1;
      check("post_rst_tx_en", tx_en, 0);

      // Clean frame after reset
      for (int i = 0; i < 12; i++) fb[i] = 8'(i * 11 + 1);
      send_frame(12, 0, 0);
      wait_en_fall();
      check_frame("post_rst", 12);
      wait_busy_low();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
